mult_ctrl: RTL and testbench

MULT_CTRL -- requirements
Module: mult_ctrl

---
 rtl/mult_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_mult_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_ctrl.sv
`default_nettype none
// ============================================================================
// mult_ctrl: arbitrates two requesters onto a fixed-latency multiplier, tracks
// tags alongside it, and buffers results for the CDB under a credit scheme.
// Optional feature macro: MULT_CTRL_FLUSH_EN (adds flush_i).
// Revision: 1.0
// ============================================================================

`ifndef ROB_IDX_W
`define ROB_IDX_W 5
`endif
`ifndef PRF_IDX_W
`define PRF_IDX_W 6
`endif

module mult_ctrl #(
  parameter int MULT_LAT  = 4,
  parameter int BUF_DEPTH = 6
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [1:0]                     req_valid_i,
  input  logic [1:0][63:0]               req_opa_i,
  input  logic [1:0][63:0]               req_opb_i,
  input  logic [1:0][`ROB_IDX_W-1:0]     req_rob_idx_i,
  input  logic [1:0][`PRF_IDX_W-1:0]     req_dest_tag_i,
  output logic [1:0]                     grant_o,
  output logic                           mult_start_o,
  output logic [63:0]                    mult_opa_o,
  output logic [63:0]                    mult_opb_o,
  input  logic                           mult_done_i,
  input  logic [63:0]                    mult_product_i,
  output logic                           cdb_req_o,
  input  logic                           cdb_gnt_i,
  output logic [63:0]                    cdb_product_o,
  output logic [`ROB_IDX_W-1:0]          cdb_rob_idx_o,
  output logic [`PRF_IDX_W-1:0]          cdb_dest_tag_o,
`ifdef MULT_CTRL_FLUSH_EN
  input  logic                           flush_i,
`endif
  output logic                           err_o
);

  localparam int c_rw    = `ROB_IDX_W;
  localparam int c_pw    = `PRF_IDX_W;
  localparam int c_cnt_w = $clog2(BUF_DEPTH + 1);
  localparam int c_ptr_w = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(BUF_DEPTH);

  logic [c_cnt_w-1:0]             r_credits, w_credits_nxt, w_busy_cnt;
  logic                           r_rr_ptr;
  logic                           r_err;
  logic [MULT_LAT-1:0]            r_busy;
  logic [MULT_LAT-1:0]            w_live;
  logic [MULT_LAT-1:0][c_rw-1:0]  r_rob;
  logic [MULT_LAT-1:0][c_pw-1:0]  r_dest;

  logic [63:0]                    r_fifo_prod [BUF_DEPTH];
  logic [c_rw-1:0]                r_fifo_rob  [BUF_DEPTH];
  logic [c_pw-1:0]                r_fifo_dest [BUF_DEPTH];
  logic [c_ptr_w-1:0]             r_head, r_tail;
  logic [c_cnt_w-1:0]             r_fcount;

  logic [1:0] w_grant;
  logic       w_issue, w_sel, w_can_issue, w_flush;
  logic       w_last_busy, w_last_live;
  logic       w_push, w_pop, w_discard, w_err_set;

`ifdef MULT_CTRL_FLUSH_EN
  logic [MULT_LAT-1:0] r_live;

  assign w_flush = flush_i;
  assign w_live  = r_live;

  always_ff @(posedge clock) begin
    if (reset || w_flush) begin
      r_live <= '0;
    end else begin
      r_live[0] <= w_issue;
      for (int i = 1; i < MULT_LAT; i++) r_live[i] <= r_live[i-1];
    end
  end
`else
  assign w_flush = 1'b0;
  assign w_live  = r_busy;
`endif

  // Credits are checked on the registered count only; a pop this cycle frees issue next cycle.
  assign w_can_issue = !reset && !w_flush && (r_credits < c_depth);

  always_comb begin
    w_grant = 2'b00;
    if (w_can_issue) begin
      if (!r_rr_ptr) begin
        if (req_valid_i[0])      w_grant = 2'b01;
        else if (req_valid_i[1]) w_grant = 2'b10;
      end else begin
        if (req_valid_i[1])      w_grant = 2'b10;
        else if (req_valid_i[0]) w_grant = 2'b01;
      end
    end
  end

  assign w_issue      = |w_grant;
  assign w_sel        = w_grant[1];
  assign grant_o      = w_grant;
  assign mult_start_o = w_issue;
  assign mult_opa_o   = w_issue ? req_opa_i[w_sel] : 64'd0;
  assign mult_opb_o   = w_issue ? req_opb_i[w_sel] : 64'd0;

  assign w_last_busy = r_busy[MULT_LAT-1];
  assign w_last_live = w_live[MULT_LAT-1];
  assign w_push      = mult_done_i && w_last_busy && w_last_live && !w_flush;
  assign w_discard   = w_last_busy && !w_last_live;
  assign w_pop       = cdb_req_o && cdb_gnt_i;
  assign w_err_set   = (mult_done_i && !w_last_busy) || (w_last_busy && !mult_done_i);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_busy <= '0;
    end else begin
      r_busy[0] <= w_issue;
      for (int i = 1; i < MULT_LAT; i++) r_busy[i] <= r_busy[i-1];
    end
  end

  always_ff @(posedge clock) begin
    r_rob[0]  <= req_rob_idx_i[w_sel];
    r_dest[0] <= req_dest_tag_i[w_sel];
    for (int i = 1; i < MULT_LAT; i++) begin
      r_rob[i]  <= r_rob[i-1];
      r_dest[i] <= r_dest[i-1];
    end
  end

  // On flush only ops that stay in the pipeline keep a credit; the last stage leaves this cycle.
  always_comb begin
    w_busy_cnt = '0;
    for (int i = 0; i < MULT_LAT - 1; i++) w_busy_cnt = w_busy_cnt + c_cnt_w'(r_busy[i]);
    if (w_flush) begin
      w_credits_nxt = w_busy_cnt;
    end else begin
      w_credits_nxt = r_credits + c_cnt_w'(w_issue) - c_cnt_w'(w_pop) - c_cnt_w'(w_discard);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_credits <= '0;
      r_rr_ptr  <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_credits <= w_credits_nxt;
      if (w_issue) r_rr_ptr <= w_grant[0];
      if (w_err_set) r_err <= 1'b1;
    end
  end

  function automatic logic [c_ptr_w-1:0] f_inc(input logic [c_ptr_w-1:0] p);
    return (p == c_ptr_w'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clock) begin
    if (reset || w_flush) begin
      r_head   <= '0;
      r_tail   <= '0;
      r_fcount <= '0;
    end else begin
      if (w_push) r_tail <= f_inc(r_tail);
      if (w_pop)  r_head <= f_inc(r_head);
      r_fcount <= r_fcount + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_fifo_prod[r_tail] <= mult_product_i;
      r_fifo_rob[r_tail]  <= r_rob[MULT_LAT-1];
      r_fifo_dest[r_tail] <= r_dest[MULT_LAT-1];
    end
  end

  assign cdb_req_o      = (r_fcount != '0);
  assign cdb_product_o  = cdb_req_o ? r_fifo_prod[r_head] : 64'd0;
  assign cdb_rob_idx_o  = cdb_req_o ? r_fifo_rob[r_head]  : '0;
  assign cdb_dest_tag_o = cdb_req_o ? r_fifo_dest[r_head] : '0;
  assign err_o          = r_err;

endmodule

`default_nettype wire

// File: tb/tb_mult_ctrl.sv
`default_nettype none
// Self-checking bench for mult_ctrl: directed scenarios plus random traffic
// against a queue-based reference of issued results and credits.

`ifndef ROB_IDX_W
`define ROB_IDX_W 5
`endif
`ifndef PRF_IDX_W
`define PRF_IDX_W 6
`endif

module tb_mult_ctrl;
  localparam int LAT   = 4;
  localparam int DEPTH = 6;
  localparam int RW    = `ROB_IDX_W;
  localparam int PW    = `PRF_IDX_W;

  logic                 clock = 1'b0;
  logic                 reset;
  logic [1:0]           req_valid_i;
  logic [1:0][63:0]     req_opa_i, req_opb_i;
  logic [1:0][RW-1:0]   req_rob_idx_i;
  logic [1:0][PW-1:0]   req_dest_tag_i;
  logic [1:0]           grant_o;
  logic                 mult_start_o;
  logic [63:0]          mult_opa_o, mult_opb_o;
  logic                 mult_done_i;
  logic [63:0]          mult_product_i;
  logic                 cdb_req_o, cdb_gnt_i;
  logic [63:0]          cdb_product_o;
  logic [RW-1:0]        cdb_rob_idx_o;
  logic [PW-1:0]        cdb_dest_tag_o;
  logic                 flush_i;
  logic                 err_o;
  logic                 force_done;

  mult_ctrl #(.MULT_LAT(LAT), .BUF_DEPTH(DEPTH)) dut (
    .clock          (clock),
    .reset          (reset),
    .req_valid_i    (req_valid_i),
    .req_opa_i      (req_opa_i),
    .req_opb_i      (req_opb_i),
    .req_rob_idx_i  (req_rob_idx_i),
    .req_dest_tag_i (req_dest_tag_i),
    .grant_o        (grant_o),
    .mult_start_o   (mult_start_o),
    .mult_opa_o     (mult_opa_o),
    .mult_opb_o     (mult_opb_o),
    .mult_done_i    (mult_done_i),
    .mult_product_i (mult_product_i),
    .cdb_req_o      (cdb_req_o),
    .cdb_gnt_i      (cdb_gnt_i),
    .cdb_product_o  (cdb_product_o),
    .cdb_rob_idx_o  (cdb_rob_idx_o),
    .cdb_dest_tag_o (cdb_dest_tag_o),
`ifdef MULT_CTRL_FLUSH_EN
    .flush_i        (flush_i),
`endif
    .err_o          (err_o)
  );

  always #5 clock = ~clock;

  // Fixed-latency multiplier stand-in: product appears LAT cycles after start.
  logic [LAT-1:0] m_v;
  logic [63:0]    m_p [LAT];
  always @(posedge clock) begin
    if (reset) begin
      m_v <= '0;
    end else begin
      m_v[0] <= mult_start_o;
      m_p[0] <= mult_opa_o * mult_opb_o;
      for (int i = 1; i < LAT; i++) begin
        m_v[i] <= m_v[i-1];
        m_p[i] <= m_p[i-1];
      end
    end
  end
  assign mult_done_i    = m_v[LAT-1] | force_done;
  assign mult_product_i = m_p[LAT-1];

  typedef struct {
    int            avail;
    logic [63:0]   prod;
    logic [RW-1:0] rob;
    logic [PW-1:0] dest;
  } res_t;

  res_t       q[$];
  int         disc[$];
  int         cyc = 0;
  bit         ptr = 1'b0;
  bit         exp_err = 1'b0;
  logic [1:0] obs_g;
  int         n_checks = 0;
  int         n_pass = 0;
  int         n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic rand_ops();
    for (int i = 0; i < 2; i++) begin
      req_opa_i[i]      = {$urandom, $urandom};
      req_opb_i[i]      = {$urandom, $urandom};
      req_rob_idx_i[i]  = RW'($urandom);
      req_dest_tag_i[i] = PW'($urandom);
    end
  endtask

  // One clock: drive, check all outputs at the falling edge, advance the model.
  task automatic run_cycle(input logic [1:0] v, input bit gnt, input bit fl, input bit fdone);
    logic [1:0] exp_g;
    bit         exp_req, sel;
    int         credits;
    res_t       e;
    req_valid_i = v;
    cdb_gnt_i   = gnt;
    flush_i     = fl;
    force_done  = fdone;
    @(negedge clock);
    credits = q.size();
    foreach (disc[i]) if (disc[i] > cyc) credits++;
    exp_g = 2'b00;
    if (!fl && credits < DEPTH) begin
      if (!ptr) exp_g = v[0] ? 2'b01 : (v[1] ? 2'b10 : 2'b00);
      else      exp_g = v[1] ? 2'b10 : (v[0] ? 2'b01 : 2'b00);
    end
    sel     = exp_g[1];
    exp_req = (q.size() > 0) && (q[0].avail <= cyc);
    obs_g   = grant_o;
    chk("grant", 64'(grant_o), 64'(exp_g));
    chk("start", 64'(mult_start_o), 64'(|exp_g));
    chk("opa", mult_opa_o, (exp_g != 0) ? req_opa_i[sel] : 64'd0);
    chk("opb", mult_opb_o, (exp_g != 0) ? req_opb_i[sel] : 64'd0);
    chk("cdb_req", 64'(cdb_req_o), 64'(exp_req));
    chk("cdb_product", cdb_product_o, exp_req ? q[0].prod : 64'd0);
    chk("cdb_rob", 64'(cdb_rob_idx_o), exp_req ? 64'(q[0].rob) : 64'd0);
    chk("cdb_dest", 64'(cdb_dest_tag_o), exp_req ? 64'(q[0].dest) : 64'd0);
    chk("err", 64'(err_o), 64'(exp_err));
    if (exp_req && gnt) void'(q.pop_front());
    if (fl) begin
      foreach (q[i]) if (q[i].avail > cyc + 1) disc.push_back(q[i].avail);
      q.delete();
    end
    if (exp_g != 0) begin
      e.avail = cyc + LAT + 1;
      e.prod  = req_opa_i[sel] * req_opb_i[sel];
      e.rob   = req_rob_idx_i[sel];
      e.dest  = req_dest_tag_i[sel];
      q.push_back(e);
      ptr = exp_g[0];
    end
    if (fdone) exp_err = 1'b1;
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1; req_valid_i = 2'b11; cdb_gnt_i = 1'b1; flush_i = 1'b0; force_done = 1'b0;
    repeat (n) begin
      @(negedge clock);
      chk("rst_grant", 64'(grant_o), 64'd0);
      chk("rst_start", 64'(mult_start_o), 64'd0);
      @(posedge clock);
      #1;
      cyc++;
    end
    reset = 1'b0; req_valid_i = 2'b00; cdb_gnt_i = 1'b0;
    q.delete(); disc.delete(); ptr = 1'b0; exp_err = 1'b0;
  endtask

  task automatic drain();
    repeat (LAT + DEPTH + 4) run_cycle(2'b00, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    int ng;
    reset = 1'b1; req_valid_i = '0; cdb_gnt_i = 1'b0; flush_i = 1'b0; force_done = 1'b0;
    req_opa_i = '0; req_opb_i = '0; req_rob_idx_i = '0; req_dest_tag_i = '0;
    #1;
    do_reset(3);
    run_cycle(2'b00, 1'b0, 1'b0, 1'b0);

    // Both requesters valid: alternating grants, results drain in issue order.
    rand_ops();
    req_rob_idx_i[0] = RW'(0);
    req_rob_idx_i[1] = RW'(1);
    repeat (4) run_cycle(2'b11, 1'b1, 1'b0, 1'b0);
    drain();

    // 3 * 7 from requester 0 reaches the CDB five cycles after issue.
    req_opa_i[0] = 64'd3; req_opb_i[0] = 64'd7;
    req_rob_idx_i[0] = RW'(5); req_dest_tag_i[0] = PW'(9);
    run_cycle(2'b01, 1'b1, 1'b0, 1'b0);
    repeat (4) run_cycle(2'b00, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    chk("prod_21", cdb_product_o, 64'd21);
    @(posedge clock); #1;
    drain();

    // Credits run out with the CDB stalled; one pop frees one issue a cycle later.
    ng = 0;
    for (int i = 0; i < 10; i++) begin
      rand_ops();
      run_cycle(2'b01, 1'b0, 1'b0, 1'b0);
      if (obs_g != 2'b00) ng++;
    end
    chk("grant_count", 64'(ng), 64'd6);
    run_cycle(2'b01, 1'b1, 1'b0, 1'b0);
    run_cycle(2'b01, 1'b0, 1'b0, 1'b0);
    run_cycle(2'b01, 1'b0, 1'b0, 1'b0);
    drain();

    for (int i = 0; i < 300; i++) begin
      rand_ops();
      run_cycle(2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0), 1'b0, 1'b0);
    end
    drain();

`ifdef MULT_CTRL_FLUSH_EN
    rand_ops();
    run_cycle(2'b01, 1'b1, 1'b0, 1'b0);
    run_cycle(2'b01, 1'b1, 1'b0, 1'b0);
    run_cycle(2'b01, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      rand_ops();
      run_cycle(2'b01, 1'b0, 1'b0, 1'b0);
    end
    drain();
`endif

    // Spurious done with an empty pipeline sets a sticky error.
    run_cycle(2'b00, 1'b1, 1'b0, 1'b1);
    repeat (4) run_cycle(2'b00, 1'b1, 1'b0, 1'b0);
    do_reset(1);
    run_cycle(2'b00, 1'b0, 1'b0, 1'b0);

    // Reset with three in flight and two buffered; issue resumes immediately.
    rand_ops();
    run_cycle(2'b01, 1'b0, 1'b0, 1'b0);
    run_cycle(2'b01, 1'b0, 1'b0, 1'b0);
    run_cycle(2'b00, 1'b0, 1'b0, 1'b0);
    run_cycle(2'b01, 1'b0, 1'b0, 1'b0);
    run_cycle(2'b01, 1'b0, 1'b0, 1'b0);
    run_cycle(2'b01, 1'b0, 1'b0, 1'b0);
    do_reset(1);
    run_cycle(2'b01, 1'b0, 1'b0, 1'b0);
    chk("post_reset_grant", 64'(obs_g), 64'd1);
    for (int i = 0; i < 12; i++) begin
      rand_ops();
      run_cycle(2'b01, ($urandom_range(0, 1) != 0), 1'b0, 1'b0);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
